// File: rtl/axi_pkg.sv
// Shared AXI constants and the refill FSM state type.
package axi_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } refill_state_e;
endpackage

// File: rtl/axi_refill_linebuf.sv
// Line buffer for one cache-line refill.
// Ports: clr zeroes every slot; we writes wdata into slot idx; line is the
// whole registered line, slot k at [k*DATA_WIDTH +: DATA_WIDTH].
module axi_refill_linebuf
  import axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BURST_BEATS = 8,
  parameter int unsigned IDX_WIDTH   = $clog2(BURST_BEATS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              we,
  input  logic [IDX_WIDTH-1:0]              idx,
  input  logic [DATA_WIDTH-1:0]             wdata,
  output logic [DATA_WIDTH*BURST_BEATS-1:0] line
);

  logic [DATA_WIDTH*BURST_BEATS-1:0] line_d, line_q;

  always_comb begin
    line_d = line_q;
    if (clr) begin
      line_d = '0;
    end
    for (int unsigned k = 0; k < BURST_BEATS; k++) begin
      if (we && (idx == IDX_WIDTH'(k))) begin
        line_d[k*DATA_WIDTH +: DATA_WIDTH] = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/axi_refill_master.sv
// AXI4 read-burst master: one refill request -> one INCR burst of
// BURST_BEATS beats, assembled into a line with an error flag.
// Ports: req_* request handshake, resp_* line/err return, AR*/R* AXI read
// channels. Define AXI_REFILL_PERF_EN to add perf_refills and
// perf_stall_cycles (saturating 32-bit counters).
module axi_refill_master
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BURST_BEATS = 8,
  parameter int unsigned LEN_WIDTH   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [DATA_WIDTH*BURST_BEATS-1:0] resp_line,
  output logic                              resp_err,
  output logic                              ARVALID,
  input  logic                              ARREADY,
  output logic [ADDR_WIDTH-1:0]             ARADDR,
  output logic [LEN_WIDTH-1:0]              ARLEN,
  output logic [2:0]                        ARSIZE,
  output logic [1:0]                        ARBURST,
  input  logic                              RVALID,
  input  logic [DATA_WIDTH-1:0]             RDATA,
  input  logic                              RLAST,
  input  logic [1:0]                        RRESP,
  output logic                              RREADY
`ifdef AXI_REFILL_PERF_EN
  ,
  output logic [31:0]                       perf_refills,
  output logic [31:0]                       perf_stall_cycles
`endif
);

  localparam int unsigned CNT_WIDTH = $clog2(BURST_BEATS);
  localparam logic [CNT_WIDTH-1:0]  LAST_BEAT = CNT_WIDTH'(BURST_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BURST_BEATS * 4 - 1);

  refill_state_e         state_d, state_q;
  logic [ADDR_WIDTH-1:0] araddr_d, araddr_q;
  logic                  arvalid_d, arvalid_q;
  logic                  rready_d, rready_q;
  logic                  resp_valid_d, resp_valid_q;
  logic                  err_d, err_q;
  logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
  logic                  buf_clr, buf_we;

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    resp_valid_d = resp_valid_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    buf_clr      = 1'b0;
    buf_we       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          araddr_d  = req_addr & LINE_MASK;
          arvalid_d = 1'b1;
          err_d     = 1'b0;
          buf_clr   = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (RVALID && rready_q) begin
          buf_we = 1'b1;
          err_d  = err_q | (RRESP != AXI_RESP_OKAY);
          // Full count or early RLAST both end the burst; RLAST must agree with the count.
          if ((cnt_q == LAST_BEAT) || RLAST) begin
            if (cnt_q == LAST_BEAT ? !RLAST : 1'b1) begin
              err_d = 1'b1;
            end
            rready_d     = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  axi_refill_linebuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_BEATS(BURST_BEATS),
    .IDX_WIDTH  (CNT_WIDTH)
  ) u_linebuf (
    .clk  (clk),
    .rst  (rst),
    .clr  (buf_clr),
    .we   (buf_we),
    .idx  (cnt_q),
    .wdata(RDATA),
    .line (resp_line)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = err_q;
  assign ARVALID    = arvalid_q;
  assign ARADDR     = araddr_q;
  assign ARLEN      = LEN_WIDTH'(BURST_BEATS - 1);
  assign ARSIZE     = AXI_SIZE_4B;
  assign ARBURST    = AXI_BURST_INCR;
  assign RREADY     = rready_q;

`ifdef AXI_REFILL_PERF_EN
  logic [31:0] refills_d, refills_q;
  logic [31:0] stall_d, stall_q;

  always_comb begin
    refills_d = refills_q;
    stall_d   = stall_q;
    if ((state_q == ST_RESP) && resp_ready && (refills_q != '1)) begin
      refills_d = refills_q + 32'd1;
    end
    if ((((state_q == ST_DATA) && !RVALID) || ((state_q == ST_ADDR) && !ARREADY))
        && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refills_q <= '0;
      stall_q   <= '0;
    end else begin
      refills_q <= refills_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_refills      = refills_q;
  assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_axi_refill_master.sv
module tb_axi_refill_master;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [255:0] resp_line;
  logic         resp_err;
  logic         ARVALID;
  logic         ARREADY = 1'b1;
  logic [31:0]  ARADDR;
  logic [7:0]   ARLEN;
  logic [2:0]   ARSIZE;
  logic [1:0]   ARBURST;
  logic         RVALID = 1'b0;
  logic [31:0]  RDATA = '0;
  logic         RLAST = 1'b0;
  logic [1:0]   RRESP = '0;
  logic         RREADY;
`ifdef AXI_REFILL_PERF_EN
  logic [31:0]  perf_refills;
  logic [31:0]  perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  axi_refill_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BURST_BEATS(8),
    .LEN_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_line (resp_line),
    .resp_err  (resp_err),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .ARADDR    (ARADDR),
    .ARLEN     (ARLEN),
    .ARSIZE    (ARSIZE),
    .ARBURST   (ARBURST),
    .RVALID    (RVALID),
    .RDATA     (RDATA),
    .RLAST     (RLAST),
    .RRESP     (RRESP),
    .RREADY    (RREADY)
`ifdef AXI_REFILL_PERF_EN
    ,
    .perf_refills     (perf_refills),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slot k holds 0x100+k for the first n slots, zero elsewhere.
  function automatic logic [255:0] exp_line(input int n);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < n; k++) l[k*32 +: 32] = 32'h100 + 32'(k);
    return l;
  endfunction

  // Called at a negedge; drives the request for one cycle.
  task automatic do_req(input logic [31:0] addr);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Slave R channel: offers nbeats beats; RLAST on beat last_at, SLVERR on err_at,
  // RVALID low in cycles whose gap_mask bit is set.
  task automatic run_beats(input int nbeats, input int last_at, input int err_at,
                           input logic [31:0] gap_mask);
    int k = 0;
    int c = 0;
    logic hs;
    while (k < nbeats && c < 200) begin
      RVALID = !gap_mask[c % 32];
      RDATA  = 32'h100 + 32'(k);
      RLAST  = (k == last_at);
      RRESP  = (k == err_at) ? 2'b10 : 2'b00;
      hs = RVALID && RREADY;
      @(negedge clk);
      if (hs) k++;
      c++;
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    RRESP  = 2'b00;
    chk("beats_accepted", 256'(k), 256'(nbeats));
  endtask

  task automatic wait_resp();
    int c = 0;
    while (!resp_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("resp_valid_seen", resp_valid, 1'b1);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_drop", resp_valid, 1'b0);
    chk("back_to_idle", req_ready, 1'b1);
  endtask

  initial begin
    int t0;

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_rready", RREADY, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_araddr", ARADDR, 32'h0);
    chk("rst_line", resp_line, 256'h0);
    chk("rst_req_ready", req_ready, 1'b1);

    // 1: basic burst, ARREADY high, back-to-back beats
    ARREADY = 1'b1;
    t0 = cyc;
    do_req(32'h0000_0044);
    chk("t1_arvalid", ARVALID, 1'b1);
    chk("t1_araddr", ARADDR, 32'h40);
    chk("t1_arlen", ARLEN, 8'd7);
    chk("t1_arsize", ARSIZE, 3'd2);
    chk("t1_arburst", ARBURST, 2'd1);
    run_beats(8, 7, -1, 32'h0);
    wait_resp();
    // Accept cycle counts as cycle 1; resp_valid lands in cycle N+3 = 11.
    chk("t1_latency", 256'(cyc - t0 + 1), 256'd11);
    chk("t1_line", resp_line, exp_line(8));
    chk("t1_err", resp_err, 1'b0);
    finish_resp();

    // 2: ARREADY held low for 5 cycles
    ARREADY = 1'b0;
    do_req(32'h0000_101C);
    for (int i = 0; i < 5; i++) begin
      chk("t2_arvalid_hold", ARVALID, 1'b1);
      chk("t2_araddr_hold", ARADDR, 32'h1000);
      chk("t2_no_rready", RREADY, 1'b0);
      @(negedge clk);
    end
    ARREADY = 1'b1;
    run_beats(8, 7, -1, 32'h0);
    wait_resp();
    chk("t2_line", resp_line, exp_line(8));
    chk("t2_err", resp_err, 1'b0);
    finish_resp();

    // 3: RVALID gaps, resp_ready held low 4 cycles
    do_req(32'h0000_2000);
    run_beats(8, 7, -1, 32'hA5C3_6B19);
    wait_resp();
    for (int i = 0; i < 4; i++) begin
      chk("t3_resp_valid_hold", resp_valid, 1'b1);
      chk("t3_line_hold", resp_line, exp_line(8));
      @(negedge clk);
    end
    chk("t3_err", resp_err, 1'b0);
    finish_resp();

    // 4: SLVERR on beat 3, then a clean request
    do_req(32'h0000_3010);
    run_beats(8, 7, 3, 32'h0);
    wait_resp();
    chk("t4_line", resp_line, exp_line(8));
    chk("t4_err", resp_err, 1'b1);
    finish_resp();
    do_req(32'h0000_3010);
    run_beats(8, 7, -1, 32'h0);
    wait_resp();
    chk("t4_clean_err", resp_err, 1'b0);
    finish_resp();

    // 5a: early RLAST on beat 5
    do_req(32'h0000_4000);
    run_beats(6, 5, -1, 32'h0);
    wait_resp();
    chk("t5_early_line", resp_line, exp_line(6));
    chk("t5_early_err", resp_err, 1'b1);
    finish_resp();
    // 5b: RLAST missing on beat 7
    do_req(32'h0000_5000);
    run_beats(8, -1, -1, 32'h0);
    wait_resp();
    chk("t5_nolast_line", resp_line, exp_line(8));
    chk("t5_nolast_err", resp_err, 1'b1);
    finish_resp();

    // 6: reset in DATA after beat 2
    do_req(32'h0000_6000);
    run_beats(3, -1, -1, 32'h0);
    chk("t6_in_data", RREADY, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_arvalid", ARVALID, 1'b0);
    chk("t6_rready", RREADY, 1'b0);
    chk("t6_resp_valid", resp_valid, 1'b0);
    chk("t6_resp_err", resp_err, 1'b0);
    chk("t6_araddr", ARADDR, 32'h0);
    chk("t6_line", resp_line, 256'h0);
    chk("t6_req_ready", req_ready, 1'b1);
    rst = 1'b0;
    do_req(32'h0000_7FFC);
    chk("t6_araddr_new", ARADDR, 32'h7FE0);
    run_beats(8, 7, -1, 32'h0);
    wait_resp();
    chk("t6_line_new", resp_line, exp_line(8));
    chk("t6_err_new", resp_err, 1'b0);
    finish_resp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_refill_master.md
Name: axi_refill_master

Overview:
AXI4 read-burst master that turns a single cache-line refill request into one INCR burst. It drives the AR channel and collects R beats into a line buffer. It returns the assembled line plus an error flag to the requester (I$/D$ miss handler). It sits directly upstream of the AXI slave memory and connects to its AR/R channels.

Parameters:
ADDR_WIDTH, 32, byte address width; matches slave ARADDR.
DATA_WIDTH, 32, R beat width; must be 32 (ARSIZE fixed 3'b010).
BURST_BEATS, 8, beats per line; power of two, 2..256.
LEN_WIDTH, 8, ARLEN width; matches the slave's ARLEN port.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
req_valid  in  1  refill request.
req_ready  out  1  block idle, can accept a request.
req_addr  in  ADDR_WIDTH  any byte address inside the target line.
resp_valid  out  1  line ready.
resp_ready  in  1  requester accepts line.
resp_line  out  DATA_WIDTH*BURST_BEATS  beat k at bits [k*DATA_WIDTH +: DATA_WIDTH].
resp_err  out  1  any RRESP!=0 or RLAST protocol violation.
ARVALID  out  1
ARREADY  in  1
ARADDR  out  ADDR_WIDTH  line-aligned address.
ARLEN  out  LEN_WIDTH  constant BURST_BEATS-1.
ARSIZE  out  3  constant 3'b010.
ARBURST  out  2  constant 2'b01 (INCR).
RVALID  in  1
RDATA  in  DATA_WIDTH
RLAST  in  1
RRESP  in  2
RREADY  out  1

Behaviour:
- Single clock `clk`; reset `rst` is synchronous, active-high. On rst: state IDLE; ARVALID=0, RREADY=0, resp_valid=0, resp_err=0, ARADDR=0, resp_line=0, beat counter=0.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: req_ready=1. On req_valid, latch req_addr with its low log2(BURST_BEATS*4) bits zeroed. Clear resp_line and err. Go to ADDR. Earliest ARVALID is the cycle after acceptance.
- ADDR: ARVALID=1. ARADDR, ARLEN, ARSIZE and ARBURST stay stable until ARREADY is sampled high. Then go to DATA with beat counter=0. ARVALID never drops without a handshake.
- DATA: RREADY=1. On each RVALID&&RREADY: write RDATA into the slot selected by the counter and OR (RRESP!=0) into err.
  - If counter==BURST_BEATS-1: set err if RLAST==0, then go to RESP.
  - Else if RLAST==1: early termination. Set err and go to RESP; unwritten slots remain 0.
  - Else increment the counter.
  - RREADY drops in the cycle following the final beat.
- RESP: resp_valid=1, resp_line/resp_err stable. On resp_ready go to IDLE. resp_valid is high for at least one cycle.
- Throughput: one outstanding burst; no AR issue until RESP completes. Back-to-back best case: req accept, AR, N beats, resp = N+3 cycles.
- Counter width: clog2(BURST_BEATS), wraps only by FSM exit.
- RVALID outside DATA: ignored (RREADY=0).
- rst mid-burst: abandon immediately to IDLE. The system resets the slave with the same reset, so no drain is required.
- A request asserted while not in IDLE is held off by req_ready=0.

Optional Feature:
AXI_REFILL_PERF_EN:
- Defined: adds outputs perf_refills[31:0] (increments on each resp handshake) and perf_stall_cycles[31:0] (increments on every DATA cycle with RVALID=0, and every ADDR cycle with ARREADY=0). Both are reset to 0 by rst and saturate at all-ones.
- Undefined: ports and counters are absent; functional behaviour is identical.

Decomposition:
- Shared package axi_pkg: AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_RESP_OKAY=2'b00, and the refill FSM state enum.
- One natural sub-module: axi_refill_linebuf (beat-indexed write, clear, full-line read). The master instantiates it; the FSM and AXI handshakes stay in the top.

Test Plan:
1. Reset, then req_addr=0x0000_0044 with ARREADY tied high, slave returning 0x100+k for beats k=0..7 with RLAST on beat 7 and RRESP=0 -> ARADDR=0x40, ARLEN=7, ARSIZE=2, ARBURST=1; resp_line slot k=0x100+k; resp_err=0; resp_valid 11 cycles after acceptance.
2. Hold ARREADY low for 5 cycles -> ARVALID stays 1 and ARADDR stays stable throughout; no RREADY until the handshake.
3. Random RVALID gaps, plus resp_ready held low for 4 cycles -> data is correct; resp_valid and resp_line stay stable until resp_ready.
4. RRESP=2'b10 on beat 3 -> full line is captured; resp_err=1. A following clean request gives resp_err=0.
5. RLAST on beat 5 -> resp_err=1; slots 6 and 7 are 0. RLAST missing on beat 7 -> resp_err=1 and the FSM still reaches RESP.
6. rst asserted in DATA after beat 2 -> next cycle: IDLE, all outputs at reset values. A new request then completes normally.
